// File: rtl/avalon_s_arbiter.sv
// rtl/avalon_s_arbiter.sv - round-robin arbiter sharing one Avalon device port between NH hosts
module avalon_s_arbiter #(
    parameter int NH = 2,
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NH-1:0]               hosts_avn_read,
    input  logic [NH-1:0]               hosts_avn_write,
    input  logic [NH-1:0][AW-1:0]       hosts_avn_address,
    input  logic [NH-1:0][DW/8-1:0]     hosts_avn_byte_enable,
    input  logic [NH-1:0][DW-1:0]       hosts_avn_writedata,
    output logic [NH-1:0][DW-1:0]       hosts_avn_readdata,
    output logic [NH-1:0]               hosts_avn_waitrequest,
    output logic                        device_avn_read,
    output logic                        device_avn_write,
    output logic [AW-1:0]               device_avn_address,
    output logic [DW/8-1:0]             device_avn_byte_enable,
    output logic [DW-1:0]               device_avn_writedata,
    input  logic [DW-1:0]               device_avn_readdata,
    input  logic                        device_avn_waitrequest
);

    localparam int PW = $clog2(NH);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [PW-1:0]   r_ptr;
    logic [NH-1:0]   r_lock_grant;
    logic [NH-1:0]   r_rd_owner;

    logic [NH-1:0]   w_req;
    logic [NH-1:0]   w_rr_grant;
    logic [NH-1:0]   w_grant;
    logic [PW-1:0]   w_win_idx;
    logic [PW-1:0]   w_ptr_next;
    logic            w_any_grant;
    logic            w_accept;
    logic            w_abort;
    logic            w_accept_eff;
    logic            w_load_lock;

    assign w_req       = hosts_avn_read | hosts_avn_write;
    assign w_any_grant = |w_grant;
    assign w_accept    = w_any_grant & ~device_avn_waitrequest;
    // A locked host that drops its request abandons the transfer; it must not advance the pointer.
    assign w_abort      = (r_state == S_LOCKED) & ~(|(r_lock_grant & w_req));
    assign w_accept_eff = w_accept & ~w_abort;
    assign w_load_lock  = (r_state == S_IDLE) & w_any_grant & device_avn_waitrequest;
    assign w_ptr_next   = (w_win_idx == PW'(NH - 1)) ? '0 : w_win_idx + PW'(1);

    // State register: lock state, with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Arbitration bookkeeping: locked grant, rotating pointer and read-return owner
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr        <= '0;
            r_lock_grant <= '0;
            r_rd_owner   <= '0;
        end else begin
            if (w_load_lock) begin
                r_lock_grant <= w_grant;
            end
            if (w_accept_eff) begin
                r_ptr <= w_ptr_next;
            end
            r_rd_owner <= (w_accept_eff & device_avn_read) ? w_grant : '0;
        end
    end

    // Next-state: lock while the device stalls a granted host, unlock on accept or abandonment
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_any_grant && device_avn_waitrequest) w_next_state = S_LOCKED;
            S_LOCKED: if (w_accept || w_abort)                   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Round-robin search starting at the pointer, wrapping modulo NH
    always_comb begin
        logic          found;
        logic [PW-1:0] idx;
        w_rr_grant = '0;
        found      = 1'b0;
        idx        = '0;
        for (int k = 0; k < NH; k++) begin
            idx = PW'((int'(r_ptr) + k) % NH);
            if (!found && w_req[idx]) begin
                w_rr_grant[idx] = 1'b1;
                found           = 1'b1;
            end
        end
    end

    // Index of the current winner, used to rotate the pointer past it
    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < NH; i++) begin
            if (w_grant[i]) w_win_idx = PW'(i);
        end
    end

    // Outputs: grant selection, one-hot command mux, waitrequest fan-out, read data steering
    always_comb begin
        w_grant                = (r_state == S_LOCKED) ? r_lock_grant : w_rr_grant;
        device_avn_read        = 1'b0;
        device_avn_write       = 1'b0;
        device_avn_address     = '0;
        device_avn_byte_enable = '0;
        device_avn_writedata   = '0;
        hosts_avn_readdata     = '0;
        hosts_avn_waitrequest  = ~w_grant | {NH{device_avn_waitrequest}};
        for (int i = 0; i < NH; i++) begin
            if (w_grant[i]) begin
                device_avn_read        = device_avn_read        | hosts_avn_read[i];
                device_avn_write       = device_avn_write       | hosts_avn_write[i];
                device_avn_address     = device_avn_address     | hosts_avn_address[i];
                device_avn_byte_enable = device_avn_byte_enable | hosts_avn_byte_enable[i];
                device_avn_writedata   = device_avn_writedata   | hosts_avn_writedata[i];
            end
            hosts_avn_readdata[i] = device_avn_readdata & {DW{r_rd_owner[i]}};
        end
    end

endmodule
